// File: rtl/operand_entry_if.sv
// Operand-entry bus: raw switch/button inputs toward the entry block and
// registered operands plus status back out to the adder stage.
interface operand_entry_if;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] x;
  logic [3:0] y;
  logic       valid;
  logic [1:0] state_led;

  modport master (
    output sw, btn_load, btn_clear,
    input  x, y, valid, state_led
  );

  modport slave (
    input  sw, btn_load, btn_clear,
    output x, y, valid, state_led
  );
endinterface

// File: rtl/operand_entry.sv
// Captures operands X then Y from slide switches on debounced load presses;
// a debounced clear press restarts entry. All outputs come straight from flops.
module operand_entry #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_entry_if.slave bus
);

  typedef enum logic [1:0] {
    S_X    = 2'b00,
    S_Y    = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int               BTN_LOAD  = 0;
  localparam int               BTN_CLEAR = 1;
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       r_sw_s1, r_sw_s2;
  logic [1:0]       r_btn_s1, r_btn_s2;
  logic [1:0]       r_deb, r_deb_d;
  logic [CNT_W-1:0] r_cnt [2];

  state_t     r_state;
  logic [3:0] r_x, r_y;
  logic       r_valid;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  logic       w_load_p, w_clear_p;

  assign w_btn_raw = {bus.btn_clear, bus.btn_load};
  // One-cycle pulse per debounced rising edge; releases give nothing.
  assign w_press   = r_deb & ~r_deb_d;
  assign w_load_p  = w_press[BTN_LOAD];
  assign w_clear_p = w_press[BTN_CLEAR];

  // Two-flop synchronizers followed by a per-button stability counter.
  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the pre-edge values; blocking would collapse the sync chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_deb    <= '0;
      r_deb_d  <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sw_s1  <= bus.sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_deb_d  <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] != r_deb[i]) begin
          if (r_cnt[i] == DEB_MAX) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Entry FSM; clear outranks load so a simultaneous load is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_X;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else if (w_clear_p) begin
      r_state <= S_X;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_X: begin
          if (w_load_p) begin
            r_x     <= r_sw_s2;
            r_state <= S_Y;
          end
        end
        S_Y: begin
          if (w_load_p) begin
            r_y     <= r_sw_s2;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_load_p) begin
            r_x     <= r_sw_s2;
            r_valid <= 1'b0;
            r_state <= S_Y;
          end
        end
        default: begin
          r_state <= S_X;
          r_x     <= '0;
          r_y     <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.valid     = r_valid;
  assign bus.state_led = r_state;

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
Upstream stage for the 4-bit adder / 7-segment display path. It captures two 4-bit operands, X then Y, from board slide switches, one per debounced press of a load push button. It presents both operands as registered values with a valid flag to the adder stage. A clear button restarts entry.

Parameters:
DEB_CYCLES, 16, consecutive stable cycles needed for a debounced button level change; minimum 2 (board builds override it with a large value).
CNT_W, 16, width of each debounce counter; must hold DEB_CYCLES-1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  4  raw slide-switch operand value (asynchronous)
btn_load  input  1  raw load push button, active-high (asynchronous, bouncy)
btn_clear  input  1  raw clear push button, active-high (asynchronous, bouncy)
x  output  4  registered operand X to adder
y  output  4  registered operand Y to adder
valid  output  1  high when x and y both hold a completed entry
state_led  output  2  entry state indicator: 00 wait X, 01 wait Y, 10 done

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizers, debounce counters and debounced levels cleared to 0; FSM = S_X; x=0, y=0, valid=0, state_led=00. Release is synchronous to clk.
- Synchronizers: sw, btn_load and btn_clear each pass through a 2-FF synchronizer. The FSM uses only synchronized sw.
- Debounce, per button: register deb and counter cnt.
  - When sync != deb, cnt increments each cycle.
  - When cnt == DEB_CYCLES-1 and sync != deb, deb toggles and cnt returns to 0.
  - Any cycle with sync == deb forces cnt to 0.
  - A glitch shorter than DEB_CYCLES cycles never changes deb.
- Edge detect: deb_d is a 1-cycle delayed copy of deb. The press pulse is deb & ~deb_d, exactly 1 cycle wide per debounced rising edge. Releases produce no pulse.
- Latency: a raw press first sampled at edge 1 updates x/y at edge DEB_CYCLES+3 (sync 2 edges, deb toggles at edge DEB_CYCLES+2, FSM acts next edge).
- FSM, acting on load_p / clear_p:
  - S_X + load_p: x <= sw_sync; go to S_Y.
  - S_Y + load_p: y <= sw_sync; valid <= 1; go to S_DONE.
  - S_DONE + load_p: x <= sw_sync; y is held; valid <= 0; go to S_Y (new entry).
  - clear_p in any state: x <= 0, y <= 0, valid <= 0, go to S_X.
  - Simultaneous clear_p and load_p: clear wins; the load is discarded.
  - No pulse: all registers hold. A held button produces only one pulse.
  - Unused state encoding 11: recovers to S_X with x=y=0, valid=0 on the next edge.
- Outputs x, y, valid and state_led are driven directly from registers, with no combinational path from sw.
- Reset asserted mid-debounce or mid-entry: the same reset values apply immediately. A button still held after reset release produces a pulse once it has been stable for DEB_CYCLES cycles.

Test Plan:
1. DEB_CYCLES=4. Reset, then sw=4'h5, clean load press (held 20 cycles) -> at edge 7 after sampling, x=5, state_led=01, valid=0; no second pulse while held.
2. Continue: sw=4'hA, press load -> y=A, valid=1, state_led=10, x still 5.
3. Bouncy load: toggle btn_load every 2 cycles for 12 cycles, then hold high -> exactly one capture, only after 4 stable cycles; no capture during the bounce.
4. In S_DONE (x=5, y=A): sw=3, press load -> x=3, y=A, valid=0, state_led=01.
5. Press load and clear so their pulses land on the same cycle -> x=0, y=0, valid=0, state_led=00; load ignored.
6. Assert rst_n low mid-way through a debounce count with x=5 -> outputs read 0/0/0/00 immediately. Button still held after release -> one capture after 4 stable cycles.
